// File: rtl/ro_freq_scanner.sv
// ---------------------------------------------------------------------------
// ro_freq_scanner
//
// Measurement end of the ring-oscillator select path. Drives the select of
// the 16:1 oscillator mux, waits for the mux output to settle, then counts
// rising edges of the muxed oscillator over a fixed gate window. Every
// channel is visited in turn and its {channel, count, overflow} is offered
// on a valid/ready result port.
//
// Optional feature macro: RO_SCAN_IRQ_EN
//   When defined, adds irq_o, a one-cycle pulse after the handshake of the
//   last channel (every wrap in continuous mode).
//
// Ports
//   wb_clk_i      in   1        system clock
//   wb_rst_ni     in   1        asynchronous active-low reset
//   start_i       in   1        pulse: begin a scan at channel 0 (ignored while busy)
//   continuous_i  in   1        1: wrap after the last channel and keep scanning
//   osc_i         in   1        muxed oscillator output (asynchronous)
//   sel_o         out  CH_BITS  mux select
//   busy_o        out  1        high in every state except IDLE
//   res_valid_o   out  1        result available
//   res_ready_i   in   1        consumer accepts the result
//   res_chan_o    out  CH_BITS  channel of the result
//   res_count_o   out  CNT_W    rising edges seen in the gate window (saturating)
//   res_ovf_o     out  1        count saturated
//   irq_o         out  1        (RO_SCAN_IRQ_EN only) end-of-scan pulse
// ---------------------------------------------------------------------------
module ro_freq_scanner #(
    parameter int CH_BITS       = 4,
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               start_i,
    input  logic               continuous_i,
    input  logic               osc_i,
    output logic [CH_BITS-1:0] sel_o,
    output logic               busy_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [CH_BITS-1:0] res_chan_o,
    output logic [CNT_W-1:0]   res_count_o,
    output logic               res_ovf_o
`ifdef RO_SCAN_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    // One shared down-the-line timer serves both the settle and gate phases,
    // so it is sized for the longer of the two.
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CH_BITS-1:0] LAST_CH     = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        REPORT
    } state_t;

    state_t             state;
    logic               osc_s1;
    logic               osc_s2;
    logic               osc_s3;
    logic               rise;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf;
    logic               ovf_next;

    // Two flops resynchronise the free-running oscillator; the third holds
    // the previous synchronised value so a rising edge is a single-cycle pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_s3 <= 1'b0;
        end else begin
            osc_s1 <= osc_i;
            osc_s2 <= osc_s1;
            osc_s3 <= osc_s2;
        end
    end

    assign rise = osc_s2 & ~osc_s3;

    // Saturating next count; a rise that arrives with the counter already
    // full marks the measurement as overflowed.
    always_comb begin
        cnt_next = edge_cnt;
        ovf_next = ovf;
        if (rise) begin
            if (&edge_cnt) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + CNT_W'(1);
            end
        end
    end

    // Scan sequencer. The result registers are loaded from the next-count
    // value so the edge seen in the final gate cycle is included.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            sel_o       <= '0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
            res_chan_o  <= '0;
            res_count_o <= '0;
            res_ovf_o   <= 1'b0;
            timer       <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
`ifdef RO_SCAN_IRQ_EN
            irq_o       <= 1'b0;
`endif
        end else begin
`ifdef RO_SCAN_IRQ_EN
            irq_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sel_o  <= '0;
                        timer  <= '0;
                        busy_o <= 1'b1;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer    <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                        state    <= GATE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                GATE: begin
                    edge_cnt <= cnt_next;
                    ovf      <= ovf_next;
                    if (timer == GATE_LAST) begin
                        timer       <= '0;
                        res_chan_o  <= sel_o;
                        res_count_o <= cnt_next;
                        res_ovf_o   <= ovf_next;
                        res_valid_o <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                REPORT: begin
                    // Backpressure simply parks here with everything frozen.
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        timer       <= '0;
                        if (sel_o != LAST_CH) begin
                            sel_o <= sel_o + CH_BITS'(1);
                            state <= SETTLE;
                        end else if (continuous_i) begin
                            sel_o <= '0;
                            state <= SETTLE;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
`ifdef RO_SCAN_IRQ_EN
                        if (sel_o == LAST_CH) begin
                            irq_o <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
